// File: rtl/xge_wb_cfg_master.sv
// xge_wb_cfg_master -- Wishbone classic master for the 10GE MAC register port.
//   Takes queued register commands (write or read), runs one single Wishbone
//   cycle per command and returns one response per command. A slave that never
//   acks is cut off after ACK_TIMEOUT cycles with rsp_timeout set.
// Ports:
//   wb_clk_i / wb_rst_i               clock, synchronous active-high reset
//   cmd_valid/ready/we/adr/dat        command push interface (into CMD FIFO)
//   rsp_valid/ready/we/adr/dat/timeout/irq  response interface, held until consumed
//   busy                              FIFO non-empty or FSM not idle
//   wb_adr_o/dat_o/we_o/cyc_o/stb_o   registered Wishbone master outputs
//   wb_ack_i/dat_i                    Wishbone slave replies
//   wb_int_i                          MAC interrupt level
// Build option: XGE_WB_IRQ_AUTOREAD_EN -- when defined, a rising edge on wb_int_i
//   queues an automatic read of ISR_ADR that takes priority over the FIFO.
//   Undefined: wb_int_i is ignored and rsp_irq is always 0.

// Generic synchronous FIFO used for the command queue.
// Latency: pushed entry visible at the output the cycle after the push.
// Backpressure: in_rdy depends only on occupancy; push and pop may coincide.
module xge_wb_cfg_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  assign in_rdy  = (cnt_q != FULL_CNT);
  assign out_vld = (cnt_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: only entries below cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat;
  end
endmodule

// Wishbone command master: FIFO -> single classic cycle -> held response.
// Latency: cyc/stb rise two edges after a push into an empty queue.
// Backpressure: no new bus cycle until the pending response is consumed.
module xge_wb_cfg_master #(
  parameter int          CMD_FIFO_DEPTH = 4,
  parameter int          ACK_TIMEOUT    = 16,
  parameter logic [7:0]  ISR_ADR        = 8'h08
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [7:0]  rsp_adr,
  output logic [31:0] rsp_dat,
  output logic        rsp_timeout,
  output logic        rsp_irq,
  output logic        busy,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_int_i
);
  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
  } cmd_t;

  // ST_LOAD is the registered launch step: address/data are loaded on the
  // edge that pops the FIFO, cyc/stb follow on the next edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // Last REQ cycle index that may still see an ack before timing out.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cur_irq_q, cur_irq_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_we_q, rsp_we_d;
  logic [7:0]  rsp_adr_q, rsp_adr_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_to_q, rsp_to_d;
  logic        rsp_irq_q, rsp_irq_d;

  cmd_t        cmd_in;
  cmd_t        fifo_head;
  logic        fifo_vld;
  logic        fifo_pop;
  logic        irq_take;
  logic        irq_issue;

  assign cmd_in.we  = cmd_we;
  assign cmd_in.adr = cmd_adr;
  assign cmd_in.dat = cmd_dat;

  xge_wb_cfg_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .in_vld  (cmd_valid),
    .in_rdy  (cmd_ready),
    .in_dat  (cmd_in),
    .out_vld (fifo_vld),
    .out_rdy (fifo_pop),
    .out_dat (fifo_head)
  );

`ifdef XGE_WB_IRQ_AUTOREAD_EN
  logic int_s_q, int_d1_q;
  logic irq_pend_q, irq_pend_d;
  logic int_rise;

  assign int_rise = int_s_q & ~int_d1_q;
  // A rise in the same cycle as the issue re-arms the request.
  assign irq_pend_d = (irq_pend_q & ~irq_issue) | int_rise;
  assign irq_take   = irq_pend_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      int_s_q    <= 1'b0;
      int_d1_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      int_s_q    <= wb_int_i;
      int_d1_q   <= int_s_q;
      irq_pend_q <= irq_pend_d;
    end
  end
`else
  logic int_unused;
  assign int_unused = wb_int_i | irq_issue;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    cur_irq_d = cur_irq_q;
    rsp_vld_d = rsp_vld_q;
    rsp_we_d  = rsp_we_q;
    rsp_adr_d = rsp_adr_q;
    rsp_dat_d = rsp_dat_q;
    rsp_to_d  = rsp_to_q;
    rsp_irq_d = rsp_irq_q;
    fifo_pop  = 1'b0;
    irq_issue = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (irq_take) begin
          adr_d     = ISR_ADR;
          dat_d     = '0;
          we_d      = 1'b0;
          cur_irq_d = 1'b1;
          irq_issue = 1'b1;
          state_d   = ST_LOAD;
        end else if (fifo_vld) begin
          fifo_pop  = 1'b1;
          adr_d     = fifo_head.adr;
          dat_d     = fifo_head.dat;
          we_d      = fifo_head.we;
          cur_irq_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cyc_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // Ack is checked before the limit so an ack on the last cycle wins.
        if (wb_ack_i) begin
          cyc_d     = 1'b0;
          rsp_vld_d = 1'b1;
          rsp_we_d  = we_q;
          rsp_adr_d = adr_q;
          rsp_dat_d = we_q ? dat_q : wb_dat_i;
          rsp_to_d  = 1'b0;
          rsp_irq_d = cur_irq_q;
          state_d   = ST_RSP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d     = 1'b0;
          rsp_vld_d = 1'b1;
          rsp_we_d  = we_q;
          rsp_adr_d = adr_q;
          rsp_dat_d = '0;
          rsp_to_d  = 1'b1;
          rsp_irq_d = cur_irq_q;
          state_d   = ST_RSP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      cnt_q     <= '0;
      cur_irq_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_we_q  <= 1'b0;
      rsp_adr_q <= '0;
      rsp_dat_q <= '0;
      rsp_to_q  <= 1'b0;
      rsp_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      cur_irq_q <= cur_irq_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_we_q  <= rsp_we_d;
      rsp_adr_q <= rsp_adr_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_to_q  <= rsp_to_d;
      rsp_irq_q <= rsp_irq_d;
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_we      = rsp_we_q;
  assign rsp_adr     = rsp_adr_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_irq     = rsp_irq_q;
  assign busy        = fifo_vld | (state_q != ST_IDLE);
endmodule

// File: tb/tb_xge_wb_cfg_master.sv
module tb_xge_wb_cfg_master;
  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_adr = 8'h00;
  logic [31:0] cmd_dat = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [7:0]  rsp_adr;
  logic [31:0] rsp_dat;
  logic        rsp_timeout;
  logic        rsp_irq;
  logic        busy;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_int_i = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave model / bus monitor state
  int          ack_at = 2;        // stb cycle number carrying the ack; 0 = never
  logic [31:0] slave_rdata = 32'h0;
  int          cyc_cnt = 0;
  int          last_len = 0;
  int          n_wb = 0;
  int          gap_cnt = 0;
  int          min_gap = 1000;
  logic [7:0]  wb_adr_log[$];

  xge_wb_cfg_master dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_adr     (cmd_adr),
    .cmd_dat     (cmd_dat),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_we      (rsp_we),
    .rsp_adr     (rsp_adr),
    .rsp_dat     (rsp_dat),
    .rsp_timeout (rsp_timeout),
    .rsp_irq     (rsp_irq),
    .busy        (busy),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_ack_i    (wb_ack_i),
    .wb_dat_i    (wb_dat_i),
    .wb_int_i    (wb_int_i)
  );

  always #5 clk = ~clk;

  // Slave: acks on the ack_at-th cycle of stb, and logs each bus cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc_o) begin
        if (cyc_cnt == 0) begin
          wb_adr_log.push_back(wb_adr_o);
          if (n_wb > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
        end
        cyc_cnt++;
        gap_cnt  = 0;
        wb_ack_i = (cyc_cnt == ack_at);
        wb_dat_i = wb_ack_i ? slave_rdata : 32'h0;
      end else begin
        if (cyc_cnt > 0) begin
          last_len = cyc_cnt;
          n_wb++;
        end
        cyc_cnt  = 0;
        gap_cnt++;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [7:0] adr, input logic [31:0] dat);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for a response; an expired bound counts as a failed comparison.
  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rsp_wait: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, k);
    end
  endtask

  task automatic consume;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_timeout, rsp_irq, busy, cmd_ready} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_ctrl: cyc,stb,we,rvld,to,irq,busy,rdy=%b required 00000001",
               {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_timeout, rsp_irq, busy, cmd_ready});
    end
    n_cmp++;
    if ({wb_adr_o, wb_dat_o, rsp_adr, rsp_dat} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_data: adr/dat/rsp=%h required 0", {wb_adr_o, wb_dat_o, rsp_adr, rsp_dat});
    end
    wb_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_write;
    ack_at = 2;
    push(1'b1, 8'h00, 32'h0000_0001);
    n_cmp++;
    if (wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_cyc_n0: cyc=%b required 0", wb_cyc_o);
    end
    tick();
    n_cmp++;
    if (wb_cyc_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_cyc_n1: cyc=%b busy=%b required 0/1", wb_cyc_o, busy);
    end
    tick();
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111 || wb_adr_o !== 8'h00 || wb_dat_o !== 32'h1) begin
      n_fail++;
      $display("FAIL write_bus_n2: cyc,stb,we=%b adr=%h dat=%h required 111/00/00000001",
               {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o, wb_dat_o);
    end
    wait_rsp("write");
    n_cmp++;
    if (rsp_we !== 1'b1 || rsp_adr !== 8'h00 || rsp_dat !== 32'h1 || rsp_timeout !== 1'b0 || rsp_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL write_rsp: we=%b adr=%h dat=%h to=%b irq=%b required 1/00/00000001/0/0",
               rsp_we, rsp_adr, rsp_dat, rsp_timeout, rsp_irq);
    end
    n_cmp++;
    if (last_len !== 2) begin
      n_fail++;
      $display("FAIL write_cyc_len: cyc high %0d cycles, required 2", last_len);
    end
    consume();
  endtask

  task automatic test_read;
    ack_at      = 2;
    slave_rdata = 32'hA5A5_0003;
    push(1'b0, 8'h0C, 32'hFFFF_FFFF);
    wait_rsp("read");
    n_cmp++;
    if (rsp_we !== 1'b0 || rsp_adr !== 8'h0C || rsp_dat !== 32'hA5A5_0003 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL read_rsp: we=%b adr=%h dat=%h to=%b required 0/0c/a5a50003/0",
               rsp_we, rsp_adr, rsp_dat, rsp_timeout);
    end
    consume();
  endtask

  task automatic test_timeout;
    ack_at      = 0;
    slave_rdata = 32'h1111_2222;
    push(1'b0, 8'h10, 32'h0);
    wait_rsp("timeout");
    n_cmp++;
    if (rsp_timeout !== 1'b1 || rsp_dat !== 32'h0 || rsp_adr !== 8'h10) begin
      n_fail++;
      $display("FAIL timeout_rsp: to=%b dat=%h adr=%h required 1/00000000/10", rsp_timeout, rsp_dat, rsp_adr);
    end
    n_cmp++;
    if (last_len !== 16) begin
      n_fail++;
      $display("FAIL timeout_cyc_len: cyc high %0d cycles, required 16", last_len);
    end
    consume();
  endtask

  task automatic test_ack_last;
    ack_at      = 16;
    slave_rdata = 32'hDEAD_BEEF;
    push(1'b0, 8'h14, 32'h0);
    wait_rsp("ack_last");
    n_cmp++;
    if (rsp_timeout !== 1'b0 || rsp_dat !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ack_last_rsp: to=%b dat=%h required 0/deadbeef", rsp_timeout, rsp_dat);
    end
    n_cmp++;
    if (last_len !== 16) begin
      n_fail++;
      $display("FAIL ack_last_cyc_len: cyc high %0d cycles, required 16", last_len);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    int n0;
    logic [7:0]  exp_adr;
    logic [31:0] exp_dat;
    ack_at      = 2;
    slave_rdata = 32'h1234_5678;
    min_gap     = 1000;
    n0          = n_wb;
    wb_adr_log.delete();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: cmd_ready=%b required 1", i, cmd_ready);
      end
      push(1'(i % 2), 8'(8'h20 + 4 * i), 32'h100 + i);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: cmd_ready=%b required 0", cmd_ready);
    end
    repeat (30) tick();
    n_cmp++;
    if ((n_wb - n0) !== 1 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_adr !== 8'h20) begin
      n_fail++;
      $display("FAIL b2b_stall: cycles=%0d rvld=%b rdy=%b adr=%h required 1/1/0/20",
               n_wb - n0, rsp_valid, cmd_ready, rsp_adr);
    end
    for (int i = 0; i < 5; i++) begin
      exp_adr = 8'(8'h20 + 4 * i);
      exp_dat = (i % 2 == 1) ? 32'h100 + i : 32'h1234_5678;
      wait_rsp("b2b");
      n_cmp++;
      if (rsp_adr !== exp_adr || rsp_we !== 1'(i % 2) || rsp_dat !== exp_dat) begin
        n_fail++;
        $display("FAIL b2b_rsp_%0d: adr=%h we=%b dat=%h required %h/%b/%h",
                 i, rsp_adr, rsp_we, rsp_dat, exp_adr, 1'(i % 2), exp_dat);
      end
      consume();
    end
    n_cmp++;
    if (wb_adr_log.size() !== 5 || min_gap < 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_bus: cycles=%0d min_gap=%0d busy=%b required 5/>=1/0",
               wb_adr_log.size(), min_gap, busy);
    end
    for (int i = 0; i < 5 && i < wb_adr_log.size(); i++) begin
      n_cmp++;
      if (wb_adr_log[i] !== 8'(8'h20 + 4 * i)) begin
        n_fail++;
        $display("FAIL b2b_order_%0d: bus adr=%h required %h", i, wb_adr_log[i], 8'(8'h20 + 4 * i));
      end
    end
  endtask

  task automatic test_reset_midreq;
    int k;
    int nb;
    ack_at = 0;
    push(1'b0, 8'h40, 32'h0);
    push(1'b1, 8'h44, 32'h5);
    k = 0;
    while (wb_cyc_o !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    repeat (3) tick();
    n_cmp++;
    if (wb_cyc_o !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreq_active: cyc=%b busy=%b required 1/1", wb_cyc_o, busy);
    end
    wb_rst_i = 1'b1;
    tick();
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreq_reset: cyc,stb,rvld,busy,rdy=%b required 00001",
               {wb_cyc_o, wb_stb_o, rsp_valid, busy, cmd_ready});
    end
    wb_rst_i = 1'b0;
    @(negedge clk);
    #1;
    nb = n_wb;
    repeat (20) tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || n_wb !== nb || wb_cyc_o !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreq_after: rvld=%b new_cycles=%0d cyc=%b busy=%b required 0/0/0/0",
               rsp_valid, n_wb - nb, wb_cyc_o, busy);
    end
  endtask

  task automatic test_irq;
    logic [7:0] exp_adr[4];
    logic       exp_irq[4];
    int         n_exp;
    ack_at      = 2;
    slave_rdata = 32'h0000_0F0F;
`ifdef XGE_WB_IRQ_AUTOREAD_EN
    n_exp = 4;
    exp_adr[0] = 8'h50; exp_irq[0] = 1'b0;
    exp_adr[1] = 8'h08; exp_irq[1] = 1'b1;
    exp_adr[2] = 8'h54; exp_irq[2] = 1'b0;
    exp_adr[3] = 8'h58; exp_irq[3] = 1'b0;
`else
    n_exp = 3;
    exp_adr[0] = 8'h50; exp_irq[0] = 1'b0;
    exp_adr[1] = 8'h54; exp_irq[1] = 1'b0;
    exp_adr[2] = 8'h58; exp_irq[2] = 1'b0;
    exp_adr[3] = 8'h00; exp_irq[3] = 1'b0;
`endif
    push(1'b0, 8'h50, 32'h0);
    push(1'b1, 8'h54, 32'h54);
    push(1'b0, 8'h58, 32'h0);
    repeat (10) tick();
    wb_int_i = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < n_exp; i++) begin
      wait_rsp("irq");
      n_cmp++;
      if (rsp_adr !== exp_adr[i] || rsp_irq !== exp_irq[i]) begin
        n_fail++;
        $display("FAIL irq_rsp_%0d: adr=%h irq=%b required %h/%b", i, rsp_adr, rsp_irq, exp_adr[i], exp_irq[i]);
      end
      consume();
    end
    repeat (10) tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_drain: rvld=%b busy=%b required 0/0", rsp_valid, busy);
    end
    wb_int_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_last();
    test_back_to_back();
    test_reset_midreq();
    test_irq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
